fp_add_extract: RTL

Operand-extract stage at the head of the dual-mode floating-point adder pipeline. It accepts operand pairs over a valid/ready handshake and buffers them in a 2-entry skid buffer. For each pair it unpacks sign/exponent/fraction per lane, orders the operands by magnitude, and derives the special-case flags. The registered results drive the e_* inputs of the extract→align pipeline register, and the stage advance is taken from that register's enable.

---
 rtl/fp_add_extract_if.sv | 23 ++
 rtl/fp_add_extract.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fp_add_extract_if.sv
// Operand handshake and extract-result bus of the FP adder extract stage.
interface fp_add_extract_if;
  logic        i_valid, o_ready, i_mode, i_sub, i_en;
  logic [63:0] i_a, i_b;
  logic        e_valid, e_mode;
  logic [1:0]  e_large_expff, e_small_expff, e_large_frac00, e_small_frac00;
  logic [1:0]  e_large_hidden_bit, e_small_hidden_bit, e_op, e_Ls;
  logic [15:0] e_large_exp, e_small_exp;
  logic [52:0] e_large_frac53, e_small_frac53;

  modport master (
    output i_valid, i_mode, i_sub, i_a, i_b, i_en,
    input  o_ready, e_valid, e_mode, e_large_expff, e_small_expff,
           e_large_frac00, e_small_frac00, e_large_hidden_bit, e_small_hidden_bit,
           e_op, e_Ls, e_large_exp, e_small_exp, e_large_frac53, e_small_frac53
  );
  modport slave (
    input  i_valid, i_mode, i_sub, i_a, i_b, i_en,
    output o_ready, e_valid, e_mode, e_large_expff, e_small_expff,
           e_large_frac00, e_small_frac00, e_large_hidden_bit, e_small_hidden_bit,
           e_op, e_Ls, e_large_exp, e_small_exp, e_large_frac53, e_small_frac53
  );
endinterface

// File: rtl/fp_add_extract.sv
// Extract stage: 2-entry skid buffer, per-lane unpack, magnitude ordering and flags.
// Lanes see zero-padded fields so one comparator serves binary32 and binary64.
module fp_add_extract_lane (
  input  logic        en_i, dbl_i, sub_i, sa_i, sb_i,
  input  logic [10:0] ea_i, eb_i,
  input  logic [51:0] fa_i, fb_i,
  output logic [10:0] lexp_o, sexp_o,
  output logic [51:0] lfrac_o, sfrac_o,
  output logic        lexpff_o, sexpff_o, lfrac00_o, sfrac00_o,
  output logic        lhid_o, shid_o, op_o, ls_o
);
  logic        b_lg, sb_eff;
  logic [10:0] le, se;
  logic [51:0] lf, sf;

  always_comb begin
    b_lg      = {eb_i, fb_i} > {ea_i, fa_i};
    sb_eff    = sb_i ^ sub_i;
    le        = b_lg ? eb_i : ea_i;
    se        = b_lg ? ea_i : eb_i;
    lf        = b_lg ? fb_i : fa_i;
    sf        = b_lg ? fa_i : fb_i;
    lexp_o    = '0;
    sexp_o    = '0;
    lfrac_o   = '0;
    sfrac_o   = '0;
    lexpff_o  = 1'b0;
    sexpff_o  = 1'b0;
    lfrac00_o = 1'b0;
    sfrac00_o = 1'b0;
    lhid_o    = 1'b0;
    shid_o    = 1'b0;
    op_o      = 1'b0;
    ls_o      = 1'b0;
    // An idle lane reports all-zero so unused output bits stay 0.
    if (en_i) begin
      lexp_o    = le;
      sexp_o    = se;
      lfrac_o   = lf;
      sfrac_o   = sf;
      lexpff_o  = dbl_i ? &le : &le[7:0];
      sexpff_o  = dbl_i ? &se : &se[7:0];
      lfrac00_o = ~|lf;
      sfrac00_o = ~|sf;
      lhid_o    = |le;
      shid_o    = |se;
      op_o      = sa_i ^ sb_eff;
      ls_o      = b_lg ? sb_eff : sa_i;
    end
  end
endmodule

module fp_add_extract (
  input logic            i_clk,
  input logic            i_clr,
  fp_add_extract_if.slave bus
);
  localparam int NUM_LANES = 2;

  typedef struct packed {
    logic        mode, sub;
    logic [63:0] a, b;
  } req_t;

  typedef struct packed {
    logic        mode;
    logic [1:0]  lexpff, sexpff, lfrac00, sfrac00, lhid, shid, op, ls;
    logic [15:0] lexp, sexp;
    logic [52:0] lfrac, sfrac;
  } res_t;

  req_t sr_q, sr_d, src, in_req;
  res_t res_q, res_d, ext;
  logic vld_q, vld_d, skid_full_q, skid_full_d, rdy_q;
  logic accept, or_ld, sr_ld;

  logic [NUM_LANES-1:0]       sa, sb, lane_en;
  logic [NUM_LANES-1:0]       lexpff, sexpff, lfrac00, sfrac00, lhid, shid, op, ls;
  logic [NUM_LANES-1:0][10:0] ea, eb, lexp, sexp;
  logic [NUM_LANES-1:0][51:0] fa, fb, lfrac, sfrac;
  logic                       unused_hi;

  assign in_req = '{mode: bus.i_mode, sub: bus.i_sub, a: bus.i_a, b: bus.i_b};
  assign accept = bus.i_valid & rdy_q;
  assign or_ld  = ~vld_q | bus.i_en;
  // SR catches the input when OR is stalled or is busy draining SR this edge.
  assign sr_ld  = accept & (~or_ld | skid_full_q);
  assign src    = skid_full_q ? sr_q : in_req;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign lane_en[k] = (k == 0) || !src.mode;
    assign sa[k] = src.mode ? src.a[63]    : src.a[32*k+31];
    assign sb[k] = src.mode ? src.b[63]    : src.b[32*k+31];
    assign ea[k] = src.mode ? src.a[62:52] : {3'b0, src.a[32*k+23 +: 8]};
    assign eb[k] = src.mode ? src.b[62:52] : {3'b0, src.b[32*k+23 +: 8]};
    assign fa[k] = src.mode ? src.a[51:0]  : {29'b0, src.a[32*k +: 23]};
    assign fb[k] = src.mode ? src.b[51:0]  : {29'b0, src.b[32*k +: 23]};

    fp_add_extract_lane u_lane (
      .en_i(lane_en[k]), .dbl_i(src.mode), .sub_i(src.sub), .sa_i(sa[k]), .sb_i(sb[k]),
      .ea_i(ea[k]), .eb_i(eb[k]), .fa_i(fa[k]), .fb_i(fb[k]),
      .lexp_o(lexp[k]), .sexp_o(sexp[k]), .lfrac_o(lfrac[k]), .sfrac_o(sfrac[k]),
      .lexpff_o(lexpff[k]), .sexpff_o(sexpff[k]), .lfrac00_o(lfrac00[k]), .sfrac00_o(sfrac00[k]),
      .lhid_o(lhid[k]), .shid_o(shid[k]), .op_o(op[k]), .ls_o(ls[k])
    );
  end

  // Lane 1 only ever carries binary32 fields; its wide upper bits are always zero.
  assign unused_hi = ^{lexp[1][10:8], sexp[1][10:8], lfrac[1][51:23], sfrac[1][51:23]};

  always_comb begin
    ext         = '0;
    ext.mode    = src.mode;
    ext.lexpff  = lexpff;
    ext.sexpff  = sexpff;
    ext.lfrac00 = lfrac00;
    ext.sfrac00 = sfrac00;
    ext.lhid    = lhid;
    ext.shid    = shid;
    ext.op      = op;
    ext.ls      = ls;
    if (src.mode) begin
      ext.lexp  = {5'b0, lexp[0]};
      ext.sexp  = {5'b0, sexp[0]};
      ext.lfrac = {lhid[0], lfrac[0]};
      ext.sfrac = {shid[0], sfrac[0]};
    end else begin
      ext.lexp  = {lexp[1][7:0], lexp[0][7:0]};
      ext.sexp  = {sexp[1][7:0], sexp[0][7:0]};
      ext.lfrac = {lhid[1], lfrac[1][22:0], 5'b0, lhid[0], lfrac[0][22:0]};
      ext.sfrac = {shid[1], sfrac[1][22:0], 5'b0, shid[0], sfrac[0][22:0]};
    end
  end

  always_comb begin
    vld_d       = vld_q;
    res_d       = res_q;
    sr_d        = sr_ld ? in_req : sr_q;
    skid_full_d = skid_full_q;
    if (or_ld) begin
      if (skid_full_q || accept) begin
        vld_d = 1'b1;
        res_d = ext;
      end else begin
        vld_d = 1'b0;
      end
    end
    if (sr_ld)                   skid_full_d = 1'b1;
    else if (or_ld && skid_full_q) skid_full_d = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_clr) begin
    if (!i_clr) begin
      vld_q       <= 1'b0;
      skid_full_q <= 1'b0;
      rdy_q       <= 1'b0;
      res_q       <= '0;
      sr_q        <= '0;
    end else begin
      vld_q       <= vld_d;
      skid_full_q <= skid_full_d;
      rdy_q       <= ~skid_full_d;
      res_q       <= res_d;
      sr_q        <= sr_d;
    end
  end

  assign bus.o_ready            = rdy_q;
  assign bus.e_valid            = vld_q;
  assign bus.e_mode             = res_q.mode;
  assign bus.e_large_expff      = res_q.lexpff;
  assign bus.e_small_expff      = res_q.sexpff;
  assign bus.e_large_frac00     = res_q.lfrac00;
  assign bus.e_small_frac00     = res_q.sfrac00;
  assign bus.e_large_hidden_bit = res_q.lhid;
  assign bus.e_small_hidden_bit = res_q.shid;
  assign bus.e_op               = res_q.op;
  assign bus.e_Ls               = res_q.ls;
  assign bus.e_large_exp        = res_q.lexp;
  assign bus.e_small_exp        = res_q.sexp;
  assign bus.e_large_frac53     = res_q.lfrac;
  assign bus.e_small_frac53     = res_q.sfrac;
endmodule
